// File: rtl/pkt_replay_source.sv
// Packet-replay source: frames loaded into a word memory over the CSR port are
// replayed slot by slot on an Avalon-ST source, with optional gap, looping and abort.
module pkt_replay_source #(
  parameter int unsigned DATAWIDTH          = 32,
  parameter int unsigned SLAVE_ADDRESSWIDTH = 4,
  parameter int unsigned NUMSLOTS           = 4,
  parameter int unsigned SLOT_WORDS         = 512,
  localparam int unsigned BYTES             = DATAWIDTH / 8,
  localparam int unsigned EMPTYWIDTH        = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0] slave_address,
  input  logic [DATAWIDTH-1:0]          slave_writedata,
  input  logic                          slave_write,
  input  logic                          slave_read,
  input  logic                          slave_chipselect,
  output logic [DATAWIDTH-1:0]          slave_readdata,
  output logic [DATAWIDTH-1:0]          src_data,
  output logic                          src_valid,
  input  logic                          src_ready,
  output logic                          src_sop,
  output logic                          src_eop,
  output logic [EMPTYWIDTH-1:0]         src_empty,
  output logic                          busy
);

  localparam int unsigned MEM_DEPTH = NUMSLOTS * SLOT_WORDS;
  localparam int unsigned MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned SLOT_IW   = (NUMSLOTS > 1) ? $clog2(NUMSLOTS) : 1;
  localparam int unsigned BEAT_W    = $clog2(SLOT_WORDS + 1);
  localparam int unsigned MAX_LEN   = SLOT_WORDS * BYTES;

  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_CTRL    = SLAVE_ADDRESSWIDTH'(0);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STATUS  = SLAVE_ADDRESSWIDTH'(1);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_MEMADDR = SLAVE_ADDRESSWIDTH'(2);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_MEMDATA = SLAVE_ADDRESSWIDTH'(3);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_GAP     = SLAVE_ADDRESSWIDTH'(4);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;

  state_t                state;
  logic [NUMSLOTS-1:0]   slot_en;
  logic                  loop_en;
  logic                  done;
  logic [15:0]           frames_sent;
  logic [MEM_AW-1:0]     mem_addr;
  logic [15:0]           gap_len;
  logic [15:0]           len_reg [NUMSLOTS];
  logic [DATAWIDTH-1:0]  mem [MEM_DEPTH];

  logic [SLOT_IW-1:0]    cur_slot;
  logic [MEM_AW-1:0]     rd_ptr;
  logic [BEAT_W-1:0]     beats_left;
  logic [EMPTYWIDTH-1:0] empty_lat;
  logic [15:0]           gap_cnt;
  logic                  abort_pend;

  logic                  cs_wr, ctrl_wr, start_req, abort_req, mem_wr, sel_loop;
  logic [NUMSLOTS-1:0]   sel_en;
  logic                  first_found, next_found, have_next;
  logic [SLOT_IW-1:0]    first_slot, next_slot, pick_slot;
  logic [15:0]           cur_len;
  logic [BEAT_W-1:0]     cur_beats;
  logic [EMPTYWIDTH-1:0] cur_empty;
  logic [31:0]           rd_word;

  assign cs_wr     = slave_chipselect & slave_write;
  assign ctrl_wr   = cs_wr && (slave_address == A_CTRL);
  assign start_req = ctrl_wr & slave_writedata[0];
  assign abort_req = ctrl_wr & slave_writedata[2];
  assign mem_wr    = cs_wr && (slave_address == A_MEMDATA) && (state == IDLE);

  // Selection sees a CTRL write landing on the same edge.
  assign sel_en    = ctrl_wr ? slave_writedata[8 +: NUMSLOTS] : slot_en;
  assign sel_loop  = ctrl_wr ? slave_writedata[1] : loop_en;

  assign cur_len   = len_reg[cur_slot];
  assign cur_beats = BEAT_W'((32'(cur_len) + BYTES - 1) / BYTES);
  assign cur_empty = EMPTYWIDTH'(32'(cur_beats) * BYTES - 32'(cur_len));

  function automatic logic [MEM_AW-1:0] slot_base(input logic [SLOT_IW-1:0] s);
    return MEM_AW'(32'(s) * SLOT_WORDS);
  endfunction

  // Lowest replayable slot, and the next replayable slot above the current one.
  always_comb begin
    first_found = 1'b0;
    first_slot  = '0;
    next_found  = 1'b0;
    next_slot   = '0;
    for (int k = int'(NUMSLOTS) - 1; k >= 0; k--) begin
      if (sel_en[k] && (len_reg[k] != 16'd0)) begin
        first_found = 1'b1;
        first_slot  = SLOT_IW'(k);
        if (k > int'(cur_slot)) begin
          next_found = 1'b1;
          next_slot  = SLOT_IW'(k);
        end
      end
    end
  end

  assign have_next = next_found | (sel_loop & first_found);
  assign pick_slot = next_found ? next_slot : first_slot;

  always_comb begin
    rd_word = '0;
    case (slave_address)
      A_CTRL: begin
        rd_word[1]              = loop_en;
        rd_word[8 +: NUMSLOTS]  = slot_en;
      end
      A_STATUS:  rd_word = {frames_sent, 14'd0, done, busy};
      A_MEMADDR: rd_word = 32'(mem_addr);
      A_GAP:     rd_word = {16'd0, gap_len};
      default: begin
        for (int k = 0; k < int'(NUMSLOTS); k++) begin
          if (slave_address == SLAVE_ADDRESSWIDTH'(5 + k)) rd_word = {16'd0, len_reg[k]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= slave_writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      slot_en        <= '0;
      loop_en        <= 1'b0;
      done           <= 1'b0;
      frames_sent    <= '0;
      mem_addr       <= '0;
      gap_len        <= '0;
      for (int k = 0; k < int'(NUMSLOTS); k++) len_reg[k] <= '0;
      cur_slot       <= '0;
      rd_ptr         <= '0;
      beats_left     <= '0;
      empty_lat      <= '0;
      gap_cnt        <= '0;
      abort_pend     <= 1'b0;
      busy           <= 1'b0;
      slave_readdata <= '0;
      src_data       <= '0;
      src_valid      <= 1'b0;
      src_sop        <= 1'b0;
      src_eop        <= 1'b0;
      src_empty      <= '0;
    end else begin
      if (ctrl_wr) begin
        slot_en <= slave_writedata[8 +: NUMSLOTS];
        loop_en <= slave_writedata[1];
      end
      if (cs_wr && (slave_address == A_MEMADDR)) mem_addr <= MEM_AW'(slave_writedata);
      else if (mem_wr)
        mem_addr <= (mem_addr == MEM_AW'(MEM_DEPTH - 1)) ? '0 : mem_addr + MEM_AW'(1);
      if (cs_wr && (slave_address == A_GAP)) gap_len <= slave_writedata[15:0];
      for (int k = 0; k < int'(NUMSLOTS); k++) begin
        if (cs_wr && (slave_address == SLAVE_ADDRESSWIDTH'(5 + k)))
          len_reg[k] <= (32'(slave_writedata[15:0]) > MAX_LEN) ? 16'(MAX_LEN) : slave_writedata[15:0];
      end
      if (abort_req && (state != IDLE)) abort_pend <= 1'b1;
      if (slave_chipselect && slave_read) slave_readdata <= DATAWIDTH'(rd_word);

      case (state)
        IDLE: begin
          if (start_req && first_found) begin
            state       <= FETCH;
            cur_slot    <= first_slot;
            rd_ptr      <= slot_base(first_slot);
            busy        <= 1'b1;
            done        <= 1'b0;
            frames_sent <= '0;
            abort_pend  <= 1'b0;
          end
        end
        FETCH: begin
          // A length cleared after selection ends the replay rather than sending nothing.
          if (cur_len == 16'd0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            abort_pend <= 1'b0;
          end else begin
            state      <= SEND;
            src_valid  <= 1'b1;
            src_sop    <= 1'b1;
            src_data   <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + MEM_AW'(1);
            beats_left <= cur_beats - BEAT_W'(1);
            empty_lat  <= cur_empty;
            src_eop    <= (cur_beats == BEAT_W'(1));
            src_empty  <= (cur_beats == BEAT_W'(1)) ? cur_empty : '0;
          end
        end
        SEND: begin
          if (src_ready) begin
            if (src_eop) begin
              src_valid   <= 1'b0;
              src_sop     <= 1'b0;
              src_eop     <= 1'b0;
              src_empty   <= '0;
              frames_sent <= frames_sent + 16'd1;
              if (abort_pend || abort_req || !have_next) begin
                state      <= IDLE;
                busy       <= 1'b0;
                done       <= 1'b1;
                abort_pend <= 1'b0;
              end else begin
                cur_slot <= pick_slot;
                rd_ptr   <= slot_base(pick_slot);
                if (gap_len != 16'd0) begin
                  state   <= GAP;
                  gap_cnt <= gap_len;
                end else begin
                  state <= FETCH;
                end
              end
            end else begin
              src_sop    <= 1'b0;
              src_data   <= mem[rd_ptr];
              rd_ptr     <= rd_ptr + MEM_AW'(1);
              beats_left <= beats_left - BEAT_W'(1);
              src_eop    <= (beats_left == BEAT_W'(1));
              src_empty  <= (beats_left == BEAT_W'(1)) ? empty_lat : '0;
            end
          end
        end
        GAP: begin
          if (abort_pend || abort_req) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            abort_pend <= 1'b0;
          end else if (gap_cnt == 16'd1) begin
            state <= FETCH;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_replay_source.sv
// Scoreboard bench for pkt_replay_source: expected beats are queued at START
// and compared against every accepted beat and every stalled beat.
`timescale 1ns/1ps
module tb_pkt_replay_source;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = 512;
  localparam int unsigned EW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] slave_address;
  logic [DW-1:0] slave_writedata;
  logic          slave_write, slave_read, slave_chipselect;
  logic [DW-1:0] slave_readdata;
  logic [DW-1:0] src_data;
  logic          src_valid, src_ready, src_sop, src_eop;
  logic [EW-1:0] src_empty;
  logic          busy;

  pkt_replay_source #(
    .DATAWIDTH(DW), .SLAVE_ADDRESSWIDTH(AW), .NUMSLOTS(NS), .SLOT_WORDS(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_writedata(slave_writedata),
    .slave_write(slave_write), .slave_read(slave_read),
    .slave_chipselect(slave_chipselect), .slave_readdata(slave_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop), .src_empty(src_empty), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         sb [$];
  int            sop_cyc [$];
  int            eop_cyc [$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  logic [DW-1:0] mdl_mem [NS*SW];
  int            mdl_len [NS];
  int            mdl_ptr;
  logic          rdy_pat [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beats are sampled mid-cycle; a beat transfers on the next rising edge if ready.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (!reset && src_valid) begin
      if (sb.size() == 0) begin
        if (src_ready) check("beat_unexpected", 64'(sb.size()), 64'd1);
      end else if (src_ready) begin
        e = sb.pop_front();
        check("beat", 64'({src_sop, src_eop, src_empty, src_data}), 64'(e));
        if (src_sop) sop_cyc.push_back(cyc);
        if (src_eop) eop_cyc.push_back(cyc);
      end else begin
        e = sb[0];
        check("stall_hold", 64'({src_sop, src_eop, src_empty, src_data}), 64'(e));
      end
    end
  end

  task automatic csr_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    slave_address = a; slave_writedata = d; slave_chipselect = 1'b1; slave_write = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0; slave_chipselect = 1'b0;
  endtask

  task automatic check_csr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    slave_address = a; slave_chipselect = 1'b1; slave_read = 1'b1;
    @(posedge clk); #1;
    slave_read = 1'b0; slave_chipselect = 1'b0;
    check(tag, 64'(slave_readdata), 64'(exp));
  endtask

  task automatic set_ptr(input int p);
    csr_write(AW'(2), DW'(p));
    mdl_ptr = p;
  endtask

  task automatic mem_word(input logic [DW-1:0] d);
    csr_write(AW'(3), d);
    mdl_mem[mdl_ptr] = d;
    mdl_ptr = (mdl_ptr + 1) % int'(NS * SW);
  endtask

  task automatic set_len(input int k, input int l);
    csr_write(AW'(5 + k), DW'(l));
    mdl_len[k] = (l > int'(SW * 4)) ? int'(SW * 4) : l;
  endtask

  task automatic push_frame(input int s);
    beat_t b;
    int    nb;
    nb = (mdl_len[s] + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      b.data  = mdl_mem[s * int'(SW) + i];
      b.sop   = (i == 0);
      b.eop   = (i == nb - 1);
      b.empty = b.eop ? EW'(nb * 4 - mdl_len[s]) : '0;
      sb.push_back(b);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_sb(input string tag, input int level, input int budget);
    int n;
    n = 0;
    while (sb.size() > level && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(sb.size()), 64'(level));
  endtask

  task automatic clear_marks();
    sop_cyc.delete();
    eop_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t_idle;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; src_ready = 1'b1;
    slave_address = '0; slave_writedata = '0;
    slave_write = 1'b0; slave_read = 1'b0; slave_chipselect = 1'b0;
    mdl_ptr = 0;
    for (int k = 0; k < int'(NS); k++) mdl_len[k] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_valid", 64'(src_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check_csr("rst_ctrl", AW'(0), 32'h0);
    check_csr("rst_status", AW'(1), 32'h0);
    check_csr("rst_gap", AW'(4), 32'h0);

    // Single frame, no backpressure
    set_ptr(0);
    mem_word(32'h01020304); mem_word(32'h05060708); mem_word(32'h090A0B0C);
    check_csr("memaddr_inc", AW'(2), 32'd3);
    check_csr("memdata_rd0", AW'(3), 32'h0);
    set_len(0, 10);
    clear_marks();
    push_frame(0);
    csr_write(AW'(0), 32'h0000_0101);
    t0 = cyc;
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_fetch_valid", 64'(src_valid), 64'd0);
    wait_idle("t1_idle", 50);
    t_idle = cyc;
    check("t1_busy_fall", 64'(t_idle - t0), 64'd4);
    check("t1_nsop", 64'(sop_cyc.size()), 64'd1);
    if (sop_cyc.size() > 0) check("t1_sop_time", 64'(sop_cyc[0] - t0), 64'd1);
    if (eop_cyc.size() > 0) check("t1_eop_time", 64'(eop_cyc[0] - t0), 64'd3);
    check("t1_drain", 64'(sb.size()), 64'd0);
    check_csr("t1_status", AW'(1), 32'h0001_0002);

    // Backpressure
    clear_marks();
    push_frame(0);
    csr_write(AW'(0), 32'h0000_0101);
    t0 = cyc;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      src_ready = rdy_pat[i];
      @(posedge clk); #1;
    end
    src_ready = 1'b1;
    wait_idle("t2_idle", 50);
    check("t2_drain", 64'(sb.size()), 64'd0);
    if (eop_cyc.size() > 0) check("t2_eop_time", 64'(eop_cyc[0] - t0), 64'd6);
    check_csr("t2_status", AW'(1), 32'h0001_0002);

    // Multi-slot with gap and a zero-length slot skipped
    set_ptr(3 * SW);
    mem_word(32'hA1A2A3A4); mem_word(32'hB1B2B3B4);
    set_len(0, 8); set_len(2, 0); set_len(3, 6);
    csr_write(AW'(4), 32'd3);
    clear_marks();
    push_frame(0); push_frame(3);
    csr_write(AW'(0), 32'h0000_0D01);
    wait_idle("t3_idle", 100);
    check("t3_drain", 64'(sb.size()), 64'd0);
    check("t3_nsop", 64'(sop_cyc.size()), 64'd2);
    if (sop_cyc.size() > 1 && eop_cyc.size() > 0)
      check("t3_gap_spacing", 64'(sop_cyc[1] - eop_cyc[0]), 64'd5);
    check_csr("t3_status", AW'(1), 32'h0002_0002);

    // Length clamp
    set_len(1, 5000);
    check_csr("len_clamp", AW'(6), 32'd2048);

    // Loop with abort on the third pass; ignored START and MEM_DATA while busy
    set_ptr(SW);
    for (int i = 0; i < 16; i++) mem_word(DW'($urandom));
    set_len(1, 64);
    csr_write(AW'(4), 32'd0);
    set_ptr(SW);
    clear_marks();
    push_frame(1); push_frame(1); push_frame(1);
    csr_write(AW'(0), 32'h0000_0203);
    repeat (3) begin @(posedge clk); #1; end
    csr_write(AW'(0), 32'h0000_0203);
    csr_write(AW'(3), 32'hDEAD_BEEF);
    check_csr("busy_memaddr", AW'(2), DW'(SW));
    wait_sb("t4_third_pass", 11, 200);
    csr_write(AW'(0), 32'h0000_0206);
    wait_idle("t4_idle", 100);
    check("t4_drain", 64'(sb.size()), 64'd0);
    check("t4_nsop", 64'(sop_cyc.size()), 64'd3);
    check_csr("t4_status", AW'(1), 32'h0003_0002);

    // START with no slots enabled
    csr_write(AW'(0), 32'h0000_0001);
    repeat (2) begin @(posedge clk); #1; end
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_valid", 64'(src_valid), 64'd0);
    check_csr("t5_status", AW'(1), 32'h0003_0002);

    // Reset during beat 5, then replay from retained memory
    push_frame(1);
    csr_write(AW'(0), 32'h0000_0201);
    wait_sb("t6_beat5", 12, 100);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_valid_drop", 64'(src_valid), 64'd0);
    check("t6_busy_drop", 64'(busy), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_ptr = 0;
    for (int k = 0; k < int'(NS); k++) mdl_len[k] = 0;
    check_csr("t6_ctrl", AW'(0), 32'h0);
    check_csr("t6_status", AW'(1), 32'h0);
    check_csr("t6_memaddr", AW'(2), 32'h0);
    check_csr("t6_gap", AW'(4), 32'h0);
    check_csr("t6_len1", AW'(6), 32'h0);
    set_len(1, 64);
    clear_marks();
    push_frame(1);
    csr_write(AW'(0), 32'h0000_0201);
    wait_idle("t6_idle", 100);
    check("t6_drain", 64'(sb.size()), 64'd0);
    check_csr("t6_status_end", AW'(1), 32'h0001_0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
